// File: rtl/alu_share_sched.sv
// Round-robin scheduler sharing one combinational ALU among NUM_REQ requesters.
// One op in flight: grant in IDLE, wait op-dependent cycles in EXEC, hold response in RESP.
module alu_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 32,
    parameter int MUL_LAT = 2,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*DW-1:0]  req_a,
    input  logic [NUM_REQ*DW-1:0]  req_b,
    input  logic [NUM_REQ*3-1:0]   req_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [DW-1:0]          rsp_result,
    output logic                   rsp_err,
    output logic [DW-1:0]          alu_a,
    output logic [DW-1:0]          alu_b,
    output logic [2:0]             alu_op,
    input  logic [DW-1:0]          alu_result,
    output logic                   busy
);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state, state_nxt;
    logic [IDW-1:0]     ptr, id, gnt_id, idx;
    logic [CW-1:0]      cyc_cnt;
    logic [NUM_REQ-1:0] gnt;
    logic               found, accept;

    logic [DW-1:0] a_arr  [NUM_REQ];
    logic [DW-1:0] b_arr  [NUM_REQ];
    logic [2:0]    op_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a[i*DW +: DW];
        assign b_arr[i]  = req_b[i*DW +: DW];
        assign op_arr[i] = req_op[i*3 +: 3];
    end

    // First asserted valid found scanning upward from ptr with wrap.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end

    assign req_ready = (state == IDLE) ? gnt : '0;
    assign accept    = (state == IDLE) && found;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_id    = id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (cyc_cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            id         <= '0;
            cyc_cnt    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 3'b000;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                alu_a   <= a_arr[gnt_id];
                alu_b   <= b_arr[gnt_id];
                alu_op  <= op_arr[gnt_id];
                id      <= gnt_id;
                cyc_cnt <= (op_arr[gnt_id] == OP_MUL) ? CW'(MUL_LAT - 1) : '0;
                ptr     <= IDW'((int'(gnt_id) + 1) % NUM_REQ);
            end
            if (state == EXEC) begin
                if (cyc_cnt != '0) begin
                    cyc_cnt <= cyc_cnt - 1'b1;
                end else begin
                    rsp_result <= alu_result;
                    rsp_err    <= (alu_op >= 3'b110);
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_share_sched.sv
// Self-checking bench for alu_share_sched: directed scenarios plus a randomized
// run checked against a round-robin / latency / ALU reference model.
module tb_alu_share_sched;
    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int ML  = 2;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_a, req_b;
    logic [NR*3-1:0]   req_op;
    logic              rsp_valid, rsp_ready, rsp_err, busy;
    logic [IDW-1:0]    rsp_id;
    logic [DW-1:0]     rsp_result, alu_a, alu_b, alu_result;
    logic [2:0]        alu_op;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_share_sched #(.NUM_REQ(NR), .DW(DW), .MUL_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .busy(busy)
    );

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a * b;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    // Shared ALU stand-in.
    assign alu_result = ref_alu(alu_a, alu_b, alu_op);

    function automatic logic [NR-1:0] rr_pick(input logic [NR-1:0] m, input int p);
        logic [NR-1:0] g;
        g = '0;
        for (int k = 0; k < NR; k++)
            if (g == '0 && m[(p + k) % NR]) g[(p + k) % NR] = 1'b1;
        return g;
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_op[i*3 +: 3]  = op;
        req_valid[i]      = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issue one op from requester i alone; return negedges from accept until rsp_valid.
    task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, output int lat);
        @(negedge clk);
        set_req(i, a, b, op);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 ||
            alu_op !== 3'd0 || rsp_id !== 2'd0 || rsp_result !== 32'd0 || rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: rsp_valid=%b busy=%b alu_a=%h alu_op=%0d rsp_id=%0d rsp_result=%h rsp_err=%b, want all 0",
                     rsp_valid, busy, alu_a, alu_op, rsp_id, rsp_result, rsp_err);
        end
        do_reset();
        tests++;
        if (req_ready !== 4'b0000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: req_ready=%b busy=%b, want 0000 0", req_ready, busy);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(2, 32'd5, 32'd3, 3'b000);
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL single_grant: req_ready=%b want 0100", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        tests++;
        if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 3'b000 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_exec: alu_a=%0d alu_b=%0d alu_op=%0d busy=%b rsp_valid=%b want 5 3 0 1 0",
                     alu_a, alu_b, alu_op, busy, rsp_valid);
        end
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd8 || rsp_id !== 2'd2 || rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL single_rsp: valid=%b result=%0d id=%0d err=%b want 1 8 2 0",
                     rsp_valid, rsp_result, rsp_id, rsp_err);
        end
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_done: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_multiply();
        int lat;
        rsp_ready = 1'b1;
        run_op(1, 32'd7, 32'd6, 3'b101, lat);
        tests++;
        if (lat !== ML + 1 || rsp_result !== 32'd42 || rsp_id !== 2'd1 || rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL multiply: lat=%0d result=%0d id=%0d err=%b want %0d 42 1 0",
                     lat, rsp_result, rsp_id, rsp_err, ML + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        int lat;
        rsp_ready = 1'b1;
        run_op(0, 32'd1, 32'd1, 3'b111, lat);
        tests++;
        if (lat !== 2 || rsp_result !== 32'hDEADBEEF || rsp_err !== 1'b1) begin
            fails++;
            $display("FAIL illegal_op: lat=%0d result=%h err=%b want 2 deadbeef 1", lat, rsp_result, rsp_err);
        end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int gid [8];
        int gcyc[8];
        int n = 0;
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, $urandom, $urandom, 3'(i));
        for (int c = 0; c < 16; c++) begin
            #1;
            if (req_ready != '0 && n < 8) begin
                for (int i = 0; i < NR; i++) if (req_ready[i]) gid[n] = i;
                gcyc[n] = c;
                n++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        tests++;
        if (n < 5) begin
            fails++;
            $display("FAIL rr_count: grants=%0d want >=5", n);
        end else begin
            for (int g = 0; g < 5; g++) begin
                tests++;
                if (gid[g] !== g % NR) begin
                    fails++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d", g, gid[g], g % NR);
                end
                if (g > 0) begin
                    tests++;
                    if (gcyc[g] - gcyc[g-1] !== 3) begin
                        fails++;
                        $display("FAIL rr_spacing[%0d]: got %0d want 3", g, gcyc[g] - gcyc[g-1]);
                    end
                end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(0, 32'd10, 32'd20, 3'b000);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        set_req(3, 32'd100, 32'd50, 3'b001);
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL bp_exec_ready: req_ready=%b want 0000", req_ready);
        end
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd30 || rsp_id !== 2'd0 ||
                rsp_err !== 1'b0 || req_ready !== 4'b0000) ok = 1'b0;
            @(negedge clk);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL bp_hold: valid=%b result=%0d id=%0d req_ready=%b want 1 30 0 0000",
                     rsp_valid, rsp_result, rsp_id, req_ready);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (req_ready !== 4'b1000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_next_grant: req_ready=%b busy=%b want 1000 0", req_ready, busy);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd50 || rsp_id !== 2'd3) begin
            fails++;
            $display("FAIL bp_second_rsp: valid=%b result=%0d id=%0d want 1 50 3", rsp_valid, rsp_result, rsp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit quiet = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(2, 32'd3, 32'd4, 3'b101);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pre: busy=%b want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_a !== 32'd0 || alu_op !== 3'd0 || rsp_result !== 32'd0) begin
            fails++;
            $display("FAIL rstmid_async: rsp_valid=%b busy=%b alu_a=%0d alu_op=%0d result=%0d want 0",
                     rsp_valid, busy, alu_a, alu_op, rsp_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        tests++;
        if (!quiet) begin
            fails++;
            $display("FAIL rstmid_no_rsp: a response or busy appeared after reset");
        end
        req_valid = 4'hF;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL rstmid_ptr: req_ready=%b want 0001", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int mptr = 0;
        int w, lat, dly;
        logic [NR-1:0] m, eg;
        logic [31:0] ea [NR];
        logic [31:0] eb [NR];
        logic [2:0]  eo [NR];
        do_reset();
        for (int it = 0; it < 60; it++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            m = NR'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) begin
                ea[i] = $urandom;
                eb[i] = $urandom;
                eo[i] = 3'($urandom_range(0, 7));
                req_a[i*DW +: DW] = ea[i];
                req_b[i*DW +: DW] = eb[i];
                req_op[i*3 +: 3]  = eo[i];
            end
            req_valid = m;
            #1;
            eg = rr_pick(m, mptr);
            tests++;
            if (req_ready !== eg) begin
                fails++;
                $display("FAIL rand_grant[%0d]: req_ready=%b want %b (valid=%b)", it, req_ready, eg, m);
            end
            if (m == '0) continue;
            w = 0;
            for (int i = 0; i < NR; i++) if (eg[i]) w = i;
            @(posedge clk);
            @(negedge clk);
            req_valid = '0;
            lat = 1;
            while (!rsp_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            tests++;
            if (lat !== ((eo[w] == 3'b101) ? ML + 1 : 2) ||
                rsp_result !== ref_alu(ea[w], eb[w], eo[w]) ||
                rsp_id !== IDW'(w) || rsp_err !== (eo[w] >= 3'b110)) begin
                fails++;
                $display("FAIL rand_rsp[%0d]: lat=%0d result=%h id=%0d err=%b want lat=%0d result=%h id=%0d err=%b",
                         it, lat, rsp_result, rsp_id, rsp_err, (eo[w] == 3'b101) ? ML + 1 : 2,
                         ref_alu(ea[w], eb[w], eo[w]), w, eo[w] >= 3'b110);
            end
            dly = $urandom_range(0, 3);
            repeat (dly) @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk);
            mptr = (w + 1) % NR;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_multiply();
        test_illegal();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
